// File: rtl/cosim_seq_pkg.sv
// Shared state encoding and constants for the co-simulation commit sequencer.
package cosim_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        TRAP = 2'd2
    } seq_state_e;

    localparam int INST_LEN   = 32;
    localparam int HARTID_LEN = 32;

endpackage

// File: rtl/cosim_bundle_fifo.sv
// Small register-based FIFO holding whole commit bundles; pointers wrap modulo DEPTH.
module cosim_bundle_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s, do_pop_s;

    // Qualify requests against the flags and compute next pointers and count.
    always_comb begin
        do_push_s = push && (count_q != DEPTH_C);
        do_pop_s  = pop && (count_q != {CNT_W{1'b0}});
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, written at the write pointer on an accepted push.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == {CNT_W{1'b0}});
    assign count = count_q;

endmodule

// File: rtl/cosim_commit_sequencer.sv
// Serialises multi-lane commit bundles into one step-or-trap event per handshake,
// lanes in ascending order with a bundle's trap after its own steps.
module cosim_commit_sequencer
    import cosim_seq_pkg::*;
#(
    parameter int COMMIT_WIDTH = 2,
    parameter int XLEN         = 64,
    parameter int DEPTH        = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [COMMIT_WIDTH-1:0]      in_valid,
    input  logic [XLEN*COMMIT_WIDTH-1:0] in_pc,
    input  logic [32*COMMIT_WIDTH-1:0]   in_inst,
    input  logic [XLEN*COMMIT_WIDTH-1:0] in_wdata,
    input  logic [XLEN*COMMIT_WIDTH-1:0] in_mstatus,
    input  logic [COMMIT_WIDTH-1:0]      in_check,
    input  logic                         in_int_xcpt,
    input  logic [XLEN-1:0]              in_cause,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_is_trap,
    output logic [XLEN-1:0]              out_pc,
    output logic [31:0]                  out_inst,
    output logic [XLEN-1:0]              out_wdata,
    output logic [XLEN-1:0]              out_mstatus,
    output logic                         out_check,
    output logic [XLEN-1:0]              out_cause,
    output logic [$clog2(DEPTH):0]       occupancy,
    output logic                         idle
);

    localparam int LANE_W  = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;
    localparam int ENTRY_W = COMMIT_WIDTH * (3 * XLEN + INST_LEN + 2) + 1 + XLEN;

    seq_state_e                   state_q, state_d;
    logic [LANE_W-1:0]            lane_q, lane_d;
    logic [ENTRY_W-1:0]           hold_q, hold_d;
    logic [ENTRY_W-1:0]           push_data_s, head_s;
    logic                         push_s, pop_s, fifo_full_s, fifo_empty_s;
    logic [COMMIT_WIDTH-1:0]      head_mask_s;
    logic                         head_found_s, next_found_s;
    logic [LANE_W-1:0]            head_lane_s, next_lane_s;

    logic [COMMIT_WIDTH-1:0]          h_mask_s, h_check_s;
    logic [XLEN*COMMIT_WIDTH-1:0]     h_pc_s, h_wdata_s, h_mstatus_s;
    logic [INST_LEN*COMMIT_WIDTH-1:0] h_inst_s;
    logic                             h_trap_s;
    logic [XLEN-1:0]                  h_cause_s;

    assign push_data_s = {in_valid, in_pc, in_inst, in_wdata, in_mstatus,
                          in_check, in_int_xcpt, in_cause};
    assign {h_mask_s, h_pc_s, h_inst_s, h_wdata_s, h_mstatus_s,
            h_check_s, h_trap_s, h_cause_s} = hold_q;
    assign head_mask_s = head_s[ENTRY_W-1 -: COMMIT_WIDTH];

    // Empty bundles (no lane, no trap) are dropped here rather than stored.
    assign in_ready = !fifo_full_s;
    assign push_s   = in_ready && ((|in_valid) || in_int_xcpt);

    cosim_bundle_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (push_data_s),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (occupancy)
    );

    // Lowest set lane of the FIFO head, and next set lane above the current one.
    always_comb begin
        head_found_s = 1'b0;
        head_lane_s  = {LANE_W{1'b0}};
        next_found_s = 1'b0;
        next_lane_s  = {LANE_W{1'b0}};
        for (int i = COMMIT_WIDTH - 1; i >= 0; i--) begin
            if (head_mask_s[i]) begin
                head_found_s = 1'b1;
                head_lane_s  = LANE_W'(i);
            end else begin
                head_found_s = head_found_s;
            end
            if (h_mask_s[i] && (i > int'(lane_q))) begin
                next_found_s = 1'b1;
                next_lane_s  = LANE_W'(i);
            end else begin
                next_found_s = next_found_s;
            end
        end
    end

    // Sequencer next state: pop into the hold register, walk lanes, then trap.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        hold_d  = hold_q;
        pop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s  = 1'b1;
                    hold_d = head_s;
                    if (head_found_s) begin
                        state_d = STEP;
                        lane_d  = head_lane_s;
                    end else begin
                        state_d = TRAP;
                        lane_d  = {LANE_W{1'b0}};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            STEP: begin
                if (out_ready) begin
                    if (next_found_s) begin
                        lane_d = next_lane_s;
                    end else if (h_trap_s) begin
                        state_d = TRAP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = STEP;
                end
            end
            TRAP: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = TRAP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, lane index and hold register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            lane_q  <= {LANE_W{1'b0}};
            hold_q  <= {ENTRY_W{1'b0}};
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            hold_q  <= hold_d;
        end
    end

    // Event outputs come only from registered state, so they hold until handshake.
    always_comb begin
        out_valid   = 1'b0;
        out_is_trap = 1'b0;
        out_pc      = {XLEN{1'b0}};
        out_inst    = {INST_LEN{1'b0}};
        out_wdata   = {XLEN{1'b0}};
        out_mstatus = {XLEN{1'b0}};
        out_check   = 1'b0;
        out_cause   = {XLEN{1'b0}};
        case (state_q)
            STEP: begin
                out_valid   = 1'b1;
                out_pc      = h_pc_s[int'(lane_q)*XLEN +: XLEN];
                out_inst    = h_inst_s[int'(lane_q)*INST_LEN +: INST_LEN];
                out_wdata   = h_wdata_s[int'(lane_q)*XLEN +: XLEN];
                out_mstatus = h_mstatus_s[int'(lane_q)*XLEN +: XLEN];
                out_check   = h_check_s[lane_q];
            end
            TRAP: begin
                out_valid   = 1'b1;
                out_is_trap = 1'b1;
                out_cause   = h_cause_s;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    assign idle = (state_q == IDLE) && fifo_empty_s;

endmodule

// File: tb/tb_cosim_commit_sequencer.sv
// Scoreboard bench: accepted bundles are expanded into expected events by a
// lane-order model; a negedge monitor compares every presented event.
module tb_cosim_commit_sequencer;

    logic          clock = 1'b0;
    logic          reset;
    logic [1:0]    in_valid;
    logic [127:0]  in_pc, in_wdata, in_mstatus;
    logic [63:0]   in_inst;
    logic [1:0]    in_check;
    logic          in_int_xcpt;
    logic [63:0]   in_cause;
    logic          in_ready, out_valid, out_ready, out_is_trap, out_check, idle;
    logic [63:0]   out_pc, out_wdata, out_mstatus, out_cause;
    logic [31:0]   out_inst;
    logic [2:0]    occupancy;

    typedef struct {
        logic [1:0]       mask;
        logic [1:0][63:0] pc;
        logic [1:0][31:0] inst;
        logic [1:0][63:0] wdata;
        logic [1:0][63:0] mstatus;
        logic [1:0]       check;
        logic             trap;
        logic [63:0]      cause;
    } bundle_t;

    typedef struct {
        logic        is_trap;
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] wdata;
        logic [63:0] mstatus;
        logic        check;
        logic [63:0] cause;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  total = 0;
    int  bad = 0;
    bit  rand_mode = 1'b0;

    cosim_commit_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_pc       (in_pc),
        .in_inst     (in_inst),
        .in_wdata    (in_wdata),
        .in_mstatus  (in_mstatus),
        .in_check    (in_check),
        .in_int_xcpt (in_int_xcpt),
        .in_cause    (in_cause),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_is_trap (out_is_trap),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .out_wdata   (out_wdata),
        .out_mstatus (out_mstatus),
        .out_check   (out_check),
        .out_cause   (out_cause),
        .occupancy   (occupancy),
        .idle        (idle)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    function automatic bundle_t blank();
        bundle_t b;
        b.mask = 2'b00; b.pc = '0; b.inst = '0; b.wdata = '0; b.mstatus = '0;
        b.check = 2'b00; b.trap = 1'b0; b.cause = 64'd0;
        return b;
    endfunction

    function automatic bundle_t rand_bundle();
        bundle_t b;
        b = blank();
        b.mask  = 2'($urandom_range(0, 3));
        b.trap  = ($urandom_range(0, 3) == 0);
        b.check = 2'($urandom_range(0, 3));
        b.cause = {$urandom, $urandom};
        for (int i = 0; i < 2; i++) begin
            b.pc[i]      = {$urandom, $urandom};
            b.inst[i]    = $urandom;
            b.wdata[i]   = {$urandom, $urandom};
            b.mstatus[i] = {$urandom, $urandom};
        end
        return b;
    endfunction

    // Reference: one step per set lane in ascending order, then the trap if flagged.
    task automatic model_push(input bundle_t b);
        ev_t e;
        for (int i = 0; i < 2; i++) begin
            if (b.mask[i]) begin
                e.is_trap = 1'b0; e.pc = b.pc[i]; e.inst = b.inst[i];
                e.wdata = b.wdata[i]; e.mstatus = b.mstatus[i];
                e.check = b.check[i]; e.cause = 64'd0;
                exp_q.push_back(e);
            end
        end
        if (b.trap) begin
            e.is_trap = 1'b1; e.pc = 64'd0; e.inst = 32'd0; e.wdata = 64'd0;
            e.mstatus = 64'd0; e.check = 1'b0; e.cause = b.cause;
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input bundle_t b);
        int guard = 0;
        in_valid = b.mask; in_pc = b.pc; in_inst = b.inst; in_wdata = b.wdata;
        in_mstatus = b.mstatus; in_check = b.check; in_int_xcpt = b.trap; in_cause = b.cause;
        @(negedge clock);
        while (!in_ready && guard < 500) begin
            tick();
            @(negedge clock);
            guard++;
        end
        if (!in_ready) chk("send_ready_timeout", in_ready, 1);
        else if (b.mask != 2'b00 || b.trap) model_push(b);
        tick();
        in_valid = 2'b00;
        in_int_xcpt = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        int n = 0;
        while (!(idle && exp_q.size() == 0) && n < max) begin
            tick();
            n++;
        end
        chk("drain_done", idle, 1);
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask

    // Monitor: every presented event must match the scoreboard head.
    always @(negedge clock) begin
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", out_valid, 0);
            end else begin
                mon_e = exp_q[0];
                chk("ev_is_trap", out_is_trap, mon_e.is_trap);
                if (mon_e.is_trap) begin
                    chk("ev_cause", out_cause, mon_e.cause);
                end else begin
                    chk("ev_pc", out_pc, mon_e.pc);
                    chk("ev_inst", out_inst, mon_e.inst);
                    chk("ev_wdata", out_wdata, mon_e.wdata);
                    chk("ev_mstatus", out_mstatus, mon_e.mstatus);
                    chk("ev_check", out_check, mon_e.check);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bundle_t b;
        reset = 1'b1; out_ready = 1'b1;
        in_valid = 2'b00; in_pc = '0; in_inst = '0; in_wdata = '0; in_mstatus = '0;
        in_check = 2'b00; in_int_xcpt = 1'b0; in_cause = 64'd0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_idle", idle, 1);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_out_pc", out_pc, 0);
        reset = 1'b0;
        tick();

        // Two-lane bundle: pop one edge after acceptance, lanes on consecutive cycles.
        b = blank(); b.mask = 2'b11;
        b.pc[0] = 64'h8000_0000; b.pc[1] = 64'h8000_0004;
        b.inst[0] = 32'h0000_0013; b.inst[1] = 32'h0010_0093;
        send(b);
        chk("lat_e0_valid", out_valid, 0);
        chk("lat_e0_occupancy", occupancy, 1);
        tick();
        chk("lat_e1_valid", out_valid, 1);
        chk("lat_e1_pc", out_pc, 64'h8000_0000);
        tick();
        chk("lane1_valid", out_valid, 1);
        chk("lane1_pc", out_pc, 64'h8000_0004);
        tick();
        chk("single_idle", idle, 1);

        // Sparse mask with trap.
        b = blank(); b.mask = 2'b10; b.pc[1] = 64'h100; b.trap = 1'b1;
        b.cause = 64'h8000_0000_0000_0007;
        send(b);
        tick();
        chk("sparse_pc", out_pc, 64'h100);
        chk("sparse_not_trap", out_is_trap, 0);
        tick();
        chk("sparse_trap", out_is_trap, 1);
        chk("sparse_cause", out_cause, 64'h8000_0000_0000_0007);
        tick();
        chk("sparse_idle", idle, 1);

        // Backpressure holds the step for five cycles.
        out_ready = 1'b0;
        b = blank(); b.mask = 2'b01; b.pc[0] = 64'h2000;
        send(b);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_pc", out_pc, 64'h2000);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_consumed", out_valid, 0);
        chk("bp_queue", exp_q.size(), 0);

        // Full FIFO: one bundle in the hold register plus four queued.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            b = blank(); b.mask = 2'b11;
            b.pc[0] = 64'h4000 + 64'(k * 16); b.pc[1] = 64'h4008 + 64'(k * 16);
            send(b);
        end
        chk("full_occupancy", occupancy, 4);
        chk("full_in_ready", in_ready, 0);
        out_ready = 1'b1;
        begin
            int n = 0;
            while (!in_ready && n < 20) begin
                tick();
                n++;
            end
        end
        chk("full_ready_rise", in_ready, 1);
        chk("full_after_pop_occ", occupancy, 3);
        wait_drain(200);

        // Reset while stepping with three bundles queued.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            b = blank(); b.mask = 2'b11; b.pc[0] = 64'h6000 + 64'(k);
            b.pc[1] = 64'h7000 + 64'(k);
            send(b);
        end
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_occupancy", occupancy, 3);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_occupancy", occupancy, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_idle", idle, 1);
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();
        chk("post_rst_idle", idle, 1);

        // Empty bundle is discarded.
        send(blank());
        chk("empty_occupancy", occupancy, 0);
        tick();
        chk("empty_no_event", out_valid, 0);
        chk("empty_idle", idle, 1);

        // Randomised traffic with random consumer backpressure.
        rand_mode = 1'b1;
        for (int k = 0; k < 80; k++) begin
            send(rand_bundle());
            if ($urandom_range(0, 4) == 0) tick();
        end
        rand_mode = 1'b0;
        out_ready = 1'b1;
        wait_drain(2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
